counter_load_controller: RTL and testbench
==========================================

# counter_load_controller

Control stage that sits directly upstream of the 8-bit up/down counter with parallel load. It drives that counter's `load_i`, `data_i`, `e_i` and `d_i` inputs, and watches its `data_o` and `cout` outputs. On a start command it presets the counter, enables counting in the requested direction, and detects terminal count through the counter's carry/borrow. It then signals completion and either halts or reloads.

## Interface
Parameters:
- `WIDTH`, default 8: preset and count width; must match the counter.

Ports:
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  start request; sampled only in IDLE.
- `stop_i`  in  1  abort; has priority over every other input.
- `pause_i`  in  1  suspends counting while in RUN.
- `preset_i`  in  WIDTH  preset value; latched when a start is accepted.
- `dir_i`  in  1  direction, latched with the preset: 0 = up, 1 = down (the counter's `d_i` convention).
- `count_i`  in  WIDTH  the counter's `data_o`; used only for status.
- `cout_i`  in  1  the counter's `cout` (carry or borrow).
- `load_o`  out  1  to the counter's `load_i`.
- `data_o`  out  WIDTH  to the counter's `data_i`; always equals the latched preset.
- `e_o`  out  1  to the counter's `e_i`.
- `d_o`  out  1  to the counter's `d_i`; always equals the latched direction.
- `busy_o`  out  1  high in LOAD, RUN and DONE.
- `done_o`  out  1  one-cycle terminal-count pulse.
- `wrap_cnt_o`  out  8  number of completed periods (see Configuration).

## Operation
- States: IDLE, LOAD, RUN, DONE. The state register and the latched preset/direction are the only registers, plus `wrap_cnt`.
- **IDLE**
  - `start_i=1` latches `preset_i` and `dir_i` and moves to LOAD.
  - Otherwise the block stays in IDLE.
- **LOAD**
  - `load_o=1`, `e_o=0`.
  - Always moves to RUN on the next edge. The counter captures the preset on that same edge.
- **RUN**
  - `e_o = ~pause_i` (combinational).
  - A terminal event is `e_o & cout_i`. It occurs at count `FF` when counting up and at count `00` when counting down.
  - On a terminal event the counter wraps on that edge and the state moves to DONE.
  - Otherwise the state stays in RUN.
- **DONE**
  - `e_o=0`, `done_o=1`.
  - Always moves to IDLE on the next edge. The counter holds its wrapped value (`00` up, `FF` down).
- **Stop**
  - `stop_i=1` in any state moves to IDLE on the next edge.
  - `e_o` and `load_o` are forced to 0 combinationally in that cycle.
  - No `done_o` pulse is generated. The counter keeps its current value.
- **Ignored inputs**
  - `start_i` is ignored outside IDLE.
  - `pause_i` is ignored outside RUN.
- **Simultaneous events**
  - Stop + start in IDLE: stays in IDLE.
  - Pause in the cycle where the count is at terminal: no terminal event; RUN continues once pause is released.
- **Outputs in IDLE:** `load_o=0`, `e_o=0`, `busy_o=0`, `done_o=0`.

## Timing
- **Reset values:**
  - State IDLE.
  - Latched preset 0, so `data_o=0`.
  - Latched direction 0, so `d_o=0`.
  - `load_o=0`, `e_o=0`, `busy_o=0`, `done_o=0`, `wrap_cnt_o=0`.
- **Reset mid-operation:**
  - The block returns to IDLE immediately, without waiting for `Clk`.
  - The counter stops advancing because `e_o` drops immediately.
- **Latency:** take `start_i` sampled at edge E0.
  - LOAD is the cycle after E0.
  - The counter equals the preset after E1.
  - The first count happens at E2.
- **Unpaused RUN length, preset P:**
  - Up: 256−P cycles.
  - Down: P+1 cycles.
- **`done_o`:** asserts in the cycle after the wrap edge and lasts exactly one cycle.
- **Back-to-back operation:** the earliest restart is `start_i` sampled in the IDLE cycle that follows DONE.

## Configuration
The macro `COUNTER_LOAD_CONTROLLER_AUTO_RELOAD_EN` selects between one-shot and auto-reload behaviour.

Macro defined (auto-reload):
- A terminal event in RUN moves to LOAD instead of DONE.
- `done_o` pulses in that LOAD cycle.
- `wrap_cnt_o` increments by 1 on the same edge, modulo 256 (`FF`→`00`).
- The latched preset and direction are reused; `preset_i` is not resampled.
- Operation continues until `stop_i` or `Rst`.
- `wrap_cnt_o` clears when a start is accepted from IDLE.

Macro undefined (one-shot):
- Behaviour is exactly as described under Operation.
- `wrap_cnt_o` is tied to `8'h00`.

## Test plan
The bench instantiates this block driving the existing counter with parallel load.
- **Up count:** Reset, then `preset_i=8'hFC`, `dir_i=0`, one-cycle start → LOAD in cycle 1, four RUN cycles (FC→FD→FE→FF→00), `done_o` pulse in cycle 6, counter holds `00`, `busy_o` low from cycle 7.
- **Down count:** `preset_i=8'h02`, `dir_i=1`, start → three RUN cycles (02→01→00→FF), `done_o` once, counter holds `FF`, `d_o=1` throughout.
- **Pause:** `preset_i=8'hFE` up, `pause_i` held for 5 cycles while the count is at `FF` → count frozen at `FF`, no `done_o`; after release, wraps to `00` and `done_o` pulses in the next cycle.
- **Stop:** `stop_i` pulsed mid-RUN at count `80` → IDLE next cycle, counter frozen at `80`, no `done_o` pulse; a `start_i` during RUN is ignored.
- **Asynchronous reset:** `Rst` asserted between clock edges during RUN → outputs at reset values before the next edge; the count no longer advances.
- **Auto-reload (macro defined):** `preset_i=8'hFD` up → `done_o` every 4 cycles (3 RUN + 1 LOAD), `wrap_cnt_o` counts 1, 2, 3…; a forced 256th wrap shows `FF`→`00`; `stop_i` halts the sequence.

Source files
------------

// File: rtl/counter_load_controller.sv
// counter_load_controller
// Control stage for an 8-bit up/down counter with parallel load. A start
// command latches a preset and a direction, loads the counter, enables
// counting, and watches the counter's carry/borrow for terminal count. When
// terminal count is reached the block signals completion and then either
// halts or reloads.
//
// Optional feature: define COUNTER_LOAD_CONTROLLER_AUTO_RELOAD_EN to select
// auto-reload. In that mode a terminal count goes straight back to a load
// cycle, which also carries the done pulse, and wrap_cnt_o counts completed
// periods. Left undefined, the block is one-shot and wrap_cnt_o is held at 0.
module counter_load_controller #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic [WIDTH-1:0] preset_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic             cout_i,
    output logic             load_o,
    output logic [WIDTH-1:0] data_o,
    output logic             e_o,
    output logic             d_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       wrap_cnt_o
);

    // RELOAD is the load cycle that follows a terminal count in auto-reload
    // mode; it differs from LOAD only in that it also raises done_o.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        RELOAD
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] preset_q;
    logic             dir_q;
    logic             accept_start;
    logic             terminal;
    logic             unused_status;

    // The counter's current value is wired in for status only; nothing in
    // the control path depends on it, so it is reduced into a sink here.
    assign unused_status = ^count_i;

    // A start counts only from IDLE, and an abort in the same cycle wins.
    assign accept_start = (state_q == IDLE) && start_i && !stop_i;

    // Terminal count is the counter's carry/borrow while actually enabled,
    // so a pause on the terminal value defers the wrap.
    assign terminal = e_o & cout_i;

    assign data_o = preset_q;
    assign d_o    = dir_q;

    // State register; reset drops straight back to IDLE without a clock.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Preset and direction are captured once per accepted start and reused
    // for every reload.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            preset_q <= '0;
            dir_q    <= 1'b0;
        end else if (accept_start) begin
            preset_q <= preset_i;
            dir_q    <= dir_i;
        end
    end

    // Counter-facing and status outputs decoded from the state; stop forces
    // the load and enable low in the very cycle it is asserted.
    always_comb begin
        load_o = 1'b0;
        e_o    = 1'b0;
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            LOAD: begin
                load_o = ~stop_i;
                busy_o = 1'b1;
            end
            RUN: begin
                e_o    = ~pause_i & ~stop_i;
                busy_o = 1'b1;
            end
            DONE: begin
                done_o = 1'b1;
                busy_o = 1'b1;
            end
            RELOAD: begin
                load_o = ~stop_i;
                done_o = 1'b1;
                busy_o = 1'b1;
            end
            default: begin
                load_o = 1'b0;
            end
        endcase
    end

    // Next-state sequencing; stop overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                end
            end
            LOAD, RELOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (terminal) begin
`ifdef COUNTER_LOAD_CONTROLLER_AUTO_RELOAD_EN
                    state_d = RELOAD;
`else
                    state_d = DONE;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (stop_i) begin
            state_d = IDLE;
        end
    end

`ifdef COUNTER_LOAD_CONTROLLER_AUTO_RELOAD_EN
    logic [7:0] wrap_q;

    // Completed-period count: cleared by a fresh start, bumped on every
    // terminal edge, rolling over from FF to 00.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wrap_q <= 8'h00;
        end else if (accept_start) begin
            wrap_q <= 8'h00;
        end else if ((state_q == RUN) && terminal) begin
            wrap_q <= wrap_q + 8'd1;
        end
    end

    assign wrap_cnt_o = wrap_q;
`else
    assign wrap_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_counter_load_controller.sv
// tb_counter_load_controller
// Drives counter_load_controller together with a simple up/down counter with
// parallel load, and compares every cycle against a period-length model of
// the controller (run length computed from the preset by arithmetic).
module tb_counter_load_controller;

    localparam int WIDTH = 8;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       start_i;
    logic       stop_i;
    logic       pause_i;
    logic [7:0] preset_i;
    logic       dir_i;
    logic       load_o;
    logic [7:0] data_o;
    logic       e_o;
    logic       d_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] wrap_cnt_o;

    logic [7:0] cnt = 8'h00;
    logic       cout;

    int   checks = 0;
    int   fails  = 0;
    logic cmp_en = 1'b0;

    always #5 Clk = ~Clk;

    counter_load_controller #(.WIDTH(WIDTH)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .pause_i   (pause_i),
        .preset_i  (preset_i),
        .dir_i     (dir_i),
        .count_i   (cnt),
        .cout_i    (cout),
        .load_o    (load_o),
        .data_o    (data_o),
        .e_o       (e_o),
        .d_o       (d_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .wrap_cnt_o(wrap_cnt_o)
    );

    // Downstream counter: carry at FF going up, borrow at 00 going down.
    assign cout = d_o ? (cnt == 8'h00) : (cnt == 8'hFF);

    always @(posedge Clk) begin
        if (load_o) begin
            cnt <= data_o;
        end else if (e_o) begin
            cnt <= d_o ? cnt - 8'd1 : cnt + 8'd1;
        end
    end

    // Reference model: an operation is "active" from the accepted start until
    // it finishes; it spends one load cycle, then a number of enabled counting
    // cycles equal to the period length, then one done cycle.
    logic       m_active;
    logic       m_load;
    logic       m_done;
    logic       m_dir;
    int         m_left;
    logic [7:0] m_preset;
    logic [7:0] m_wrap;

    function automatic int periodLen(input logic [7:0] p, input logic down);
        return down ? int'(p) + 1 : 256 - int'(p);
    endfunction

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_active <= 1'b0;
            m_load   <= 1'b0;
            m_done   <= 1'b0;
            m_left   <= 0;
            m_preset <= 8'h00;
            m_dir    <= 1'b0;
            m_wrap   <= 8'h00;
        end else if (stop_i) begin
            m_active <= 1'b0;
            m_load   <= 1'b0;
            m_done   <= 1'b0;
        end else if (!m_active) begin
            if (start_i) begin
                m_active <= 1'b1;
                m_load   <= 1'b1;
                m_preset <= preset_i;
                m_dir    <= dir_i;
                m_left   <= periodLen(preset_i, dir_i);
`ifdef COUNTER_LOAD_CONTROLLER_AUTO_RELOAD_EN
                m_wrap   <= 8'h00;
`endif
            end
        end else if (m_load) begin
            m_load <= 1'b0;
            m_done <= 1'b0;
        end else if (m_done) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
        end else if (!pause_i) begin
            if (m_left == 1) begin
                m_done <= 1'b1;
`ifdef COUNTER_LOAD_CONTROLLER_AUTO_RELOAD_EN
                m_load <= 1'b1;
                m_wrap <= m_wrap + 8'd1;
                m_left <= periodLen(m_preset, m_dir);
`endif
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    logic in_run;
    always @(negedge Clk) begin
        if (cmp_en && !Rst) begin
            in_run = m_active && !m_load && !m_done;
            checkOutput("load_o", load_o, m_load && !stop_i);
            checkOutput("e_o", e_o, in_run && !pause_i && !stop_i);
            checkOutput("busy_o", busy_o, m_active);
            checkOutput("done_o", done_o, m_done);
            checkOutput("data_o", data_o, m_preset);
            checkOutput("d_o", d_o, m_dir);
            checkOutput("wrap_cnt_o", wrap_cnt_o, m_wrap);
        end
    end

    task automatic applyStimulus(input logic st, input logic sp, input logic pa,
                                 input logic [7:0] pr, input logic di);
        start_i  = st;
        stop_i   = sp;
        pause_i  = pa;
        preset_i = pr;
        dir_i    = di;
        @(posedge Clk);
        #1;
    endtask

    // One start at cycle 0, then cycles 1..ncyc with optional pause window,
    // stop cycle and extra start cycle; ends with a stop so the block idles.
    task automatic runDirected(input logic [7:0] pr, input logic di,
                               input int pause_lo, input int pause_hi,
                               input int stop_at, input int start_at, input int ncyc,
                               output int first_done, output int pulses,
                               output logic [7:0] cnt_end, output logic busy_after);
        first_done = -1;
        pulses     = 0;
        busy_after = 1'bx;
        applyStimulus(1'b1, 1'b0, 1'b0, pr, di);
        for (int k = 1; k <= ncyc; k++) begin
            start_i = (k == start_at);
            stop_i  = (k == stop_at);
            pause_i = (k >= pause_lo) && (k <= pause_hi);
            @(negedge Clk);
            if (done_o === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = k;
            end
            if ((first_done >= 0) && (k == first_done + 1)) busy_after = busy_o;
            @(posedge Clk);
            #1;
        end
        cnt_end = cnt;
        applyStimulus(1'b0, 1'b1, 1'b0, pr, di);
        stop_i = 1'b0;
    endtask

    int         fd;
    int         np;
    logic [7:0] ce;
    logic       ba;
    logic       rdir;
    logic [7:0] rpre;

    initial begin
        Rst      = 1'b1;
        start_i  = 1'b0;
        stop_i   = 1'b0;
        pause_i  = 1'b0;
        preset_i = 8'h00;
        dir_i    = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        checkOutput("reset load_o", load_o, 0);
        checkOutput("reset e_o", e_o, 0);
        checkOutput("reset busy_o", busy_o, 0);
        checkOutput("reset done_o", done_o, 0);
        checkOutput("reset data_o", data_o, 0);
        checkOutput("reset d_o", d_o, 0);
        checkOutput("reset wrap_cnt_o", wrap_cnt_o, 0);
        Rst    = 1'b0;
        cmp_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("[TB] up count from FC");
        runDirected(8'hFC, 1'b0, 0, -1, -1, -1, 12, fd, np, ce, ba);
        checkOutput("up first done cycle", fd, 6);
`ifdef COUNTER_LOAD_CONTROLLER_AUTO_RELOAD_EN
        checkOutput("up busy after done", ba, 1);
`else
        checkOutput("up busy after done", ba, 0);
        checkOutput("up done pulses", np, 1);
        checkOutput("up counter holds", ce, 8'h00);
`endif

        $display("[TB] down count from 02");
        runDirected(8'h02, 1'b1, 0, -1, -1, -1, 12, fd, np, ce, ba);
        checkOutput("down first done cycle", fd, 5);
`ifndef COUNTER_LOAD_CONTROLLER_AUTO_RELOAD_EN
        checkOutput("down done pulses", np, 1);
        checkOutput("down counter holds", ce, 8'hFF);
`endif

        $display("[TB] pause at FF");
        runDirected(8'hFE, 1'b0, 3, 7, -1, -1, 12, fd, np, ce, ba);
        checkOutput("pause first done cycle", fd, 9);
`ifndef COUNTER_LOAD_CONTROLLER_AUTO_RELOAD_EN
        checkOutput("pause done pulses", np, 1);
        checkOutput("pause counter holds", ce, 8'h00);
`endif

        $display("[TB] stop at 80 with ignored start");
        runDirected(8'h7E, 1'b0, 0, -1, 4, 3, 10, fd, np, ce, ba);
        checkOutput("stop done pulses", np, 0);
        checkOutput("stop counter frozen", ce, 8'h80);

        $display("[TB] asynchronous reset during run");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h10, 1'b0);
        #1;
        Rst = 1'b1;
        #1;
        checkOutput("areset e_o", e_o, 0);
        checkOutput("areset load_o", load_o, 0);
        checkOutput("areset busy_o", busy_o, 0);
        checkOutput("areset done_o", done_o, 0);
        checkOutput("areset data_o", data_o, 0);
        checkOutput("areset count at reset", cnt, 8'h12);
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("areset count frozen", cnt, 8'h12);
        Rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

`ifdef COUNTER_LOAD_CONTROLLER_AUTO_RELOAD_EN
        $display("[TB] auto-reload from FD");
        runDirected(8'hFD, 1'b0, 0, -1, -1, -1, 14, fd, np, ce, ba);
        checkOutput("reload first done cycle", fd, 5);
        checkOutput("reload done pulses", np, 3);
        checkOutput("reload busy after stop", busy_o, 0);

        $display("[TB] auto-reload wrap counter rollover");
        np = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        for (int k = 0; k < 600; k++) begin
            @(negedge Clk);
            if (done_o === 1'b1) begin
                np++;
                if (np == 1)   checkOutput("wrap count first", wrap_cnt_o, 8'h01);
                if (np == 255) checkOutput("wrap count 255", wrap_cnt_o, 8'hFF);
                if (np == 256) checkOutput("wrap count rollover", wrap_cnt_o, 8'h00);
            end
            @(posedge Clk);
            #1;
        end
        checkOutput("wrap pulses in window", (np >= 256), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
        stop_i = 1'b0;
        checkOutput("wrap stop busy", busy_o, 0);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                #2;
                Rst = 1'b1;
                @(posedge Clk);
                #1;
                Rst = 1'b0;
            end else begin
                rdir = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 0) begin
                    rpre = 8'($urandom_range(0, 255));
                end else begin
                    rpre = rdir ? 8'($urandom_range(0, 6)) : 8'($urandom_range(249, 255));
                end
                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 99) < 2,
                              $urandom_range(0, 4) == 0, rpre, rdir);
            end
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
